laser500_bank_mapper: RTL and testbench

- Sits between the T80s CPU bus and the sdram controller.
- Decodes the Laser 500 paging scheme: four 16 KB CPU pages, each mapped to one of 16 physical 16 KB banks by I/O-writable bank registers.
- Produces SDRAM byte addresses with read/write request strobes, holds the CPU with WAIT_n until SDRAM acknowledges, and returns read data.
- Enforces ROM write protection and unmapped-bank behaviour.

---
 rtl/laser500_bank_mapper.sv | 156 +++++++++++++++
 tb/tb_laser500_bank_mapper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser500_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : laser500_bank_mapper
// Description : Laser 500 paging decoder between the T80s bus and SDRAM.
// Revision    : 1.0
// ============================================================================
module laser500_bank_mapper #(
    parameter logic [7:0]  IO_BASE       = 8'h40,
    parameter logic [15:0] RESET_BANKS   = 16'h7410,
    parameter logic [3:0]  ROM_LAST      = 4'd3,
    parameter logic [3:0]  RAM_LAST      = 4'd7,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF,
    parameter logic [7:0]  TIMEOUT       = 8'd255
) (
    input  logic        F14M,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_req,
    output logic        sdram_we,
    input  logic        sdram_ack,
    input  logic [7:0]  sdram_dout,
    output logic [15:0] bank_regs
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_mem_act;
    logic       r_io_act;
    logic       r_mem_prev;
    logic       r_io_prev;
    logic       r_wr;
    logic [7:0] r_cnt;

    logic       w_mem_start;
    logic       w_io_start;
    logic [3:0] w_bank;
    logic [3:0] w_io_nib;
    logic [7:0] w_io_off;
    logic       w_io_hit;

    assign w_mem_start = r_mem_act & ~r_mem_prev;
    assign w_io_start  = r_io_act & ~r_io_prev;
    assign w_bank      = bank_regs[{cpu_addr[15:14], 2'b00} +: 4];
    assign w_io_nib    = bank_regs[{cpu_addr[1:0], 2'b00} +: 4];
    assign w_io_off    = cpu_addr[7:0] - IO_BASE;
    assign w_io_hit    = (w_io_off < 8'd4);

    // Strobes are registered once; starts are rising edges of the activity.
    always_ff @(posedge F14M or posedge reset) begin
        if (reset) begin
            r_mem_act  <= 1'b0;
            r_io_act   <= 1'b0;
            r_mem_prev <= 1'b0;
            r_io_prev  <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_mem_act  <= ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
            r_io_act   <= ~cpu_iorq_n & cpu_m1_n & (~cpu_rd_n | ~cpu_wr_n);
            r_mem_prev <= r_mem_act;
            r_io_prev  <= r_io_act;
            r_wr       <= ~cpu_wr_n;
        end
    end

    always_ff @(posedge F14M or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            cpu_din    <= UNMAPPED_DATA;
            cpu_wait_n <= 1'b1;
            sdram_addr <= 25'd0;
            sdram_din  <= 8'd0;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            bank_regs  <= RESET_BANKS;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_start) begin
                        if (w_bank > RAM_LAST) begin
                            if (!r_wr) begin
                                cpu_din <= UNMAPPED_DATA;
                            end
                            r_state <= S_HOLD;
                        end else if (r_wr && (w_bank <= ROM_LAST)) begin
                            r_state <= S_HOLD;
                        end else begin
                            sdram_addr <= {7'd0, w_bank, cpu_addr[13:0]};
                            sdram_din  <= cpu_dout;
                            sdram_we   <= r_wr;
                            sdram_req  <= 1'b1;
                            cpu_wait_n <= 1'b0;
                            r_state    <= S_ISSUE;
                        end
                    end else if (w_io_start) begin
                        if (w_io_hit) begin
                            if (r_wr) begin
                                bank_regs[{cpu_addr[1:0], 2'b00} +: 4] <= cpu_dout[3:0];
                            end else begin
                                cpu_din <= {4'hF, w_io_nib};
                            end
                        end
                        r_state <= S_HOLD;
                    end
                end
                S_ISSUE: begin
                    sdram_req <= 1'b0;
                    r_cnt     <= 8'd0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (sdram_ack) begin
                        if (!sdram_we) begin
                            cpu_din <= sdram_dout;
                        end
                        cpu_wait_n <= 1'b1;
                        r_state    <= S_HOLD;
                    end else if (r_cnt == TIMEOUT) begin
                        // Abandon the access so a dead controller cannot hang the CPU.
                        if (!sdram_we) begin
                            cpu_din <= UNMAPPED_DATA;
                        end
                        cpu_wait_n <= 1'b1;
                        r_state    <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (!r_mem_act && !r_io_act) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_laser500_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser500_bank_mapper
// Description : Table, random and corner-case checks of the bank mapper.
// Revision    : 1.0
// ============================================================================
module tb_laser500_bank_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic [7:0]  cpu_din;
    logic        cpu_wait_n;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_req, sdram_we, sdram_ack;
    logic [7:0]  sdram_dout;
    logic [15:0] bank_regs;

    always #5 clk = ~clk;

    laser500_bank_mapper dut (
        .F14M       (clk),
        .reset      (rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_m1_n   (cpu_m1_n),
        .cpu_din    (cpu_din),
        .cpu_wait_n (cpu_wait_n),
        .sdram_addr (sdram_addr),
        .sdram_din  (sdram_din),
        .sdram_req  (sdram_req),
        .sdram_we   (sdram_we),
        .sdram_ack  (sdram_ack),
        .sdram_dout (sdram_dout),
        .bank_regs  (bank_regs)
    );

    int n_vec = 0;
    int n_err = 0;

    // SDRAM contents seen by the responder, and the reference copy.
    logic [7:0] sd      [0:262143];
    logic [7:0] ref_mem [0:262143];

    // Reference model state
    logic [3:0]  m_bm [4];
    logic [7:0]  m_din;
    bit          e_req, e_we;
    logic [24:0] e_addr;
    logic [7:0]  e_wdat;

    // Observations from one access
    int          o_reqs, o_stall;
    bit          o_done, o_we;
    logic [24:0] o_addr;
    logic [7:0]  o_wdat, o_cpu_din;
    logic [15:0] o_banks;

    typedef struct {
        bit          io;
        bit          wr;
        bit          m1;
        logic [15:0] addr;
        logic [7:0]  dat;
        bit          x_req;
        logic [24:0] x_addr;
        bit          x_we;
        logic [7:0]  x_din;
        logic [15:0] x_banks;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_banks();
        return {m_bm[3], m_bm[2], m_bm[1], m_bm[0]};
    endfunction

    task automatic model_reset();
        m_bm[0] = 4'd0; m_bm[1] = 4'd1; m_bm[2] = 4'd4; m_bm[3] = 4'd7;
        m_din = 8'hFF;
    endtask

    // Expected effect of one CPU access, from the paging rules.
    task automatic model_access(input bit io, input bit wr, input bit m1,
                                input logic [15:0] addr, input logic [7:0] dat);
        logic [3:0]  bank;
        logic [17:0] loc;
        int          port;
        bank = m_bm[addr[15:14]];
        loc  = {bank, addr[13:0]};
        e_req = 0; e_we = 0; e_addr = '0; e_wdat = '0;
        if (!io) begin
            if (bank > 4'd7) begin
                if (!wr) m_din = 8'hFF;
            end else if (!(wr && bank <= 4'd3)) begin
                e_req  = 1;
                e_addr = {7'd0, loc};
                e_we   = wr;
                e_wdat = dat;
                if (wr) ref_mem[loc] = dat;
                else    m_din = ref_mem[loc];
            end
        end else if (m1) begin
            port = int'(addr[7:0]);
            if (port >= 'h40 && port <= 'h43) begin
                if (wr) m_bm[port - 'h40] = dat[3:0];
                else    m_din = {4'hF, m_bm[port - 'h40]};
            end
        end
    endtask

    // Drive one CPU cycle and play the SDRAM side; ack comes two cycles after req.
    task automatic dut_access(input bit io, input bit wr, input bit m1,
                              input logic [15:0] addr, input logic [7:0] dat,
                              input bit withhold);
        int ack_at;
        o_reqs = 0; o_stall = 0; o_done = 0; ack_at = -1;
        o_addr = '0; o_we = 0; o_wdat = '0;
        cpu_addr = addr; cpu_dout = dat; cpu_m1_n = m1;
        if (io) cpu_iorq_n = 1'b0; else cpu_mreq_n = 1'b0;
        if (wr) cpu_wr_n = 1'b0;   else cpu_rd_n = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sdram_ack = 1'b0;
            if (!cpu_wait_n) o_stall++;
            if (sdram_req) begin
                o_reqs++;
                o_addr = sdram_addr; o_we = sdram_we; o_wdat = sdram_din;
                if (!withhold) ack_at = c + 2;
            end
            if (c == ack_at) begin
                sdram_ack = 1'b1;
                if (o_we) begin
                    sd[o_addr[17:0]] = o_wdat;
                    sdram_dout = 8'($urandom);
                end else begin
                    sdram_dout = sd[o_addr[17:0]];
                end
            end
            if (c >= 4 && cpu_wait_n && c > ack_at) begin
                o_done = 1;
                break;
            end
        end
        check("wait_release", 32'(o_done), 32'd1);
        o_cpu_din = cpu_din;
        o_banks   = bank_regs;
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sdram_ack = 1'b0;
            if (sdram_req) o_reqs++;
        end
    endtask

    task automatic run_checked(input bit io, input bit wr, input bit m1,
                               input logic [15:0] addr, input logic [7:0] dat);
        model_access(io, wr, m1, addr, dat);
        dut_access(io, wr, m1, addr, dat, 1'b0);
        check("req_count", o_reqs, 32'(e_req));
        if (e_req) begin
            check("sdram_addr", 32'(o_addr), 32'(e_addr));
            check("sdram_we", 32'(o_we), 32'(e_we));
            if (e_we) check("sdram_din", 32'(o_wdat), 32'(e_wdat));
        end
        check("stall", o_stall, e_req ? 32'd3 : 32'd0);
        check("cpu_din", 32'(o_cpu_din), 32'(m_din));
        check("bank_regs", 32'(o_banks), 32'(m_banks()));
    endtask

    task automatic late_ack(input logic [7:0] exp_din);
        sdram_dout = 8'h55;
        sdram_ack  = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        @(negedge clk);
        check("late_ack_din", 32'(cpu_din), 32'(exp_din));
        check("late_ack_wait", 32'(cpu_wait_n), 32'd1);
        check("late_ack_req", 32'(sdram_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_dout = '0;
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        sdram_ack = 1'b0; sdram_dout = '0;
        for (int i = 0; i < 262144; i++) begin
            sd[i] = 8'($urandom);
            ref_mem[i] = sd[i];
        end
        sd[18'h00123] = 8'h3E;
        ref_mem[18'h00123] = 8'h3E;
        model_reset();

        //               io wr m1 addr      dat    req addr          we din    banks
        tbl[0]  = '{0, 0, 1, 16'h0123, 8'h00, 1, 25'h0000123, 0, 8'h3E, 16'h7410};
        tbl[1]  = '{1, 1, 1, 16'h0042, 8'h05, 0, 25'h0000000, 0, 8'h3E, 16'h7510};
        tbl[2]  = '{0, 1, 1, 16'h8010, 8'hA5, 1, 25'h0014010, 1, 8'h3E, 16'h7510};
        tbl[3]  = '{0, 1, 1, 16'h4000, 8'h11, 0, 25'h0000000, 0, 8'h3E, 16'h7510};
        tbl[4]  = '{1, 1, 1, 16'h0043, 8'h0C, 0, 25'h0000000, 0, 8'h3E, 16'hC510};
        tbl[5]  = '{0, 0, 1, 16'hC000, 8'h00, 0, 25'h0000000, 0, 8'hFF, 16'hC510};
        tbl[6]  = '{1, 0, 1, 16'h0043, 8'h00, 0, 25'h0000000, 0, 8'hFC, 16'hC510};
        tbl[7]  = '{0, 0, 1, 16'h8010, 8'h00, 1, 25'h0014010, 0, 8'hA5, 16'hC510};
        tbl[8]  = '{1, 1, 1, 16'h0045, 8'h33, 0, 25'h0000000, 0, 8'hA5, 16'hC510};
        tbl[9]  = '{1, 1, 0, 16'h0040, 8'h06, 0, 25'h0000000, 0, 8'hA5, 16'hC510};
        tbl[10] = '{1, 1, 1, 16'h0043, 8'h07, 0, 25'h0000000, 0, 8'hA5, 16'h7510};

        repeat (2) @(negedge clk);
        check("rst_cpu_din", 32'(cpu_din), 32'hFF);
        check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_we", 32'(sdram_we), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_sdin", 32'(sdram_din), 32'd0);
        check("rst_banks", 32'(bank_regs), 32'h7410);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            model_access(tbl[i].io, tbl[i].wr, tbl[i].m1, tbl[i].addr, tbl[i].dat);
            dut_access(tbl[i].io, tbl[i].wr, tbl[i].m1, tbl[i].addr, tbl[i].dat, 1'b0);
            check($sformatf("t%0d_req", i), o_reqs, 32'(tbl[i].x_req));
            if (tbl[i].x_req) begin
                check($sformatf("t%0d_addr", i), 32'(o_addr), 32'(tbl[i].x_addr));
                check($sformatf("t%0d_we", i), 32'(o_we), 32'(tbl[i].x_we));
                if (tbl[i].x_we) check($sformatf("t%0d_sdin", i), 32'(o_wdat), 32'(tbl[i].dat));
            end
            check($sformatf("t%0d_stall", i), o_stall, tbl[i].x_req ? 32'd3 : 32'd0);
            check($sformatf("t%0d_din", i), 32'(o_cpu_din), 32'(tbl[i].x_din));
            check($sformatf("t%0d_banks", i), 32'(o_banks), 32'(tbl[i].x_banks));
        end

        for (int i = 0; i < 150; i++) begin
            bit          io, wr, m1;
            logic [15:0] addr;
            io   = ($urandom_range(0, 3) == 0);
            wr   = 1'($urandom);
            m1   = ($urandom_range(0, 9) != 0);
            addr = io ? 16'(16'h0040 + $urandom_range(0, 7)) : 16'($urandom);
            run_checked(io, wr, io ? m1 : 1'b1, addr, 8'($urandom));
        end

        // Ack withheld: access must time out with unmapped data.
        run_checked(1, 1, 1, 16'h0040, 8'h02);
        model_access(0, 0, 1, 16'h0007, 8'h00);
        m_din = 8'hFF;
        dut_access(0, 0, 1, 16'h0007, 8'h00, 1'b1);
        check("to_req", o_reqs, 32'd1);
        check("to_addr", 32'(o_addr), 32'h0008007);
        check("to_stall_range", 32'(o_stall >= 250 && o_stall <= 260), 32'd1);
        check("to_din", 32'(o_cpu_din), 32'hFF);
        late_ack(8'hFF);

        // Asynchronous reset in the middle of an access.
        run_checked(1, 1, 1, 16'h0041, 8'h09);
        cpu_addr = 16'h0010; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_wait_low", 32'(cpu_wait_n), 32'd0);
        rst = 1'b1;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        #1;
        check("ar_wait_n", 32'(cpu_wait_n), 32'd1);
        check("ar_req", 32'(sdram_req), 32'd0);
        check("ar_banks", 32'(bank_regs), 32'h7410);
        check("ar_din", 32'(cpu_din), 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        late_ack(8'hFF);
        run_checked(0, 0, 1, 16'h0010, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
